// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time from
// instruction memory and holds it, pre-split into decoder fields, until the
// decoder consumes it. The next PC is chosen at consume time from PCSrc.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds valid and its payload stable until then.
// The memory response is valid-only and is accepted only while waiting for
// the single outstanding request.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic [31:0] fetch_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        req_fire;
  logic        consume_fire;
  logic        pctarget_unused;

  // Target is forced to word alignment; the low bits are simply dropped.
  assign pctarget_unused = ^PCTarget[1:0];

  // Request is suppressed while reset is held so nothing leaks out before
  // the memory side has left reset too.
  assign imem_req_valid = (state_q == S_REQ) && !reset;
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instr_valid    = (state_q == S_HOLD);
  assign consume_fire   = instr_valid && instr_ready;

  assign instr          = instr_q;
  assign op             = instr_q[6:0];
  assign funct3         = instr_q[14:12];
  assign funct7         = instr_q[30];
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign fetch_count    = fetch_count_q;
  assign dbg_state      = state_q;

  // Next-state logic for the REQ -> WAIT -> HOLD fetch cycle.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      S_REQ: begin
        if (req_fire) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (consume_fire) begin
          pc_d          = PCSrc ? {PCTarget[31:2], 2'b00} : pc_plus4;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // State registers with synchronous reset; a pending response is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule
